// File: rtl/vend_session_ctrl.sv
// ============================================================================
// Module   : vend_session_ctrl
// Purpose  : Vending transaction controller: coin credit, vend handshake,
//            nickel change/refund, inventory and inactivity timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_session_ctrl #(
   parameter int PRICE       = 9,
   parameter int STOCK_INIT  = 8,
   parameter int STOCK_W     = 4,
   parameter int TIMEOUT_CYC = 1000,
   parameter int TMR_W       = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic coin_n,
   input  logic coin_d,
   input  logic coin_q,
   input  logic sel_valid,
   input  logic sel_diet,
   input  logic cancel,
   input  logic restock,
   input  logic disp_ack,
   input  logic chg_ack,
   output logic disp_soda,
   output logic disp_diet,
   output logic chg_req,
   output logic [3:0] credit,
   output logic coin_reject,
   output logic sel_reject,
   output logic soda_empty,
   output logic diet_empty,
   output logic busy
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   localparam logic [3:0]         c_price      = 4'(PRICE);
   localparam logic [STOCK_W-1:0] c_stock_init = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] c_stock_one  = STOCK_W'(1);
   localparam logic [TMR_W-1:0]   c_tmr_last   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0]   c_tmr_one    = TMR_W'(1);

   state_t             r_state, w_state;
   logic [3:0]         r_credit, w_credit;
   logic [TMR_W-1:0]   r_timer, w_timer;
   logic [STOCK_W-1:0] r_soda_stock, w_soda_stock;
   logic [STOCK_W-1:0] r_diet_stock, w_diet_stock;
   logic               r_disp_soda, w_disp_soda;
   logic               r_disp_diet, w_disp_diet;
   logic               r_chg_req, w_chg_req;
   logic               r_coin_reject, w_coin_reject;
   logic               r_sel_reject, w_sel_reject;

   logic               w_coin_any;
   logic               w_coin_multi;
   logic               w_coin_take;
   logic [3:0]         w_coin_val;
   logic               w_stock_ok;

   // Only the highest-priority coin is valued; any other coin is lost.
   assign w_coin_any   = coin_n | coin_d | coin_q;
   assign w_coin_multi = (coin_n & (coin_d | coin_q)) | (coin_d & coin_q);
   assign w_coin_val   = coin_n ? 4'd1 : (coin_d ? 4'd2 : (coin_q ? 4'd5 : 4'd0));
   assign w_stock_ok   = sel_diet ? (r_diet_stock != '0) : (r_soda_stock != '0);

   always_comb begin
      w_state      = r_state;
      w_credit     = r_credit;
      w_timer      = r_timer;
      w_soda_stock = r_soda_stock;
      w_diet_stock = r_diet_stock;
      w_disp_soda  = r_disp_soda;
      w_disp_diet  = r_disp_diet;
      w_sel_reject = 1'b0;
      w_coin_take  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_timer = '0;
            if (restock) begin
               w_soda_stock = c_stock_init;
               w_diet_stock = c_stock_init;
            end
            if (sel_valid)
               w_sel_reject = 1'b1;
            if (w_coin_any) begin
               w_coin_take = 1'b1;
               w_credit    = r_credit + w_coin_val;
               w_state     = ST_CREDIT;
            end
         end
         ST_CREDIT: begin
            // Priority: selection, then cancel, then timeout, then coin.
            if (sel_valid) begin
               if (r_credit >= c_price && w_stock_ok) begin
                  if (sel_diet)
                     w_diet_stock = r_diet_stock - c_stock_one;
                  else
                     w_soda_stock = r_soda_stock - c_stock_one;
                  w_credit    = r_credit - c_price;
                  w_disp_soda = ~sel_diet;
                  w_disp_diet = sel_diet;
                  w_timer     = '0;
                  w_state     = ST_DISPENSE;
               end else begin
                  w_sel_reject = 1'b1;
                  w_timer      = r_timer + c_tmr_one;
               end
            end else if (cancel || r_timer >= c_tmr_last) begin
               w_timer = '0;
               w_state = ST_CHANGE;
            end else if (w_coin_any && r_credit < c_price) begin
               w_coin_take = 1'b1;
               w_credit    = r_credit + w_coin_val;
               w_timer     = '0;
            end else begin
               w_timer = r_timer + c_tmr_one;
            end
         end
         ST_DISPENSE: begin
            if (disp_ack) begin
               w_disp_soda = 1'b0;
               w_disp_diet = 1'b0;
               w_state     = (r_credit != 4'd0) ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_CHANGE: begin
            if (r_credit == 4'd0) begin
               w_state = ST_IDLE;
            end else if (r_chg_req && chg_ack) begin
               w_credit = r_credit - 4'd1;
               if (r_credit == 4'd1)
                  w_state = ST_IDLE;
            end
         end
         default: w_state = ST_IDLE;
      endcase

      w_chg_req     = (w_state == ST_CHANGE) && (w_credit != 4'd0);
      w_coin_reject = w_coin_any && (!w_coin_take || w_coin_multi);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_credit      <= 4'd0;
         r_timer       <= '0;
         r_soda_stock  <= c_stock_init;
         r_diet_stock  <= c_stock_init;
         r_disp_soda   <= 1'b0;
         r_disp_diet   <= 1'b0;
         r_chg_req     <= 1'b0;
         r_coin_reject <= 1'b0;
         r_sel_reject  <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_credit      <= w_credit;
         r_timer       <= w_timer;
         r_soda_stock  <= w_soda_stock;
         r_diet_stock  <= w_diet_stock;
         r_disp_soda   <= w_disp_soda;
         r_disp_diet   <= w_disp_diet;
         r_chg_req     <= w_chg_req;
         r_coin_reject <= w_coin_reject;
         r_sel_reject  <= w_sel_reject;
      end
   end

   assign disp_soda   = r_disp_soda;
   assign disp_diet   = r_disp_diet;
   assign chg_req     = r_chg_req;
   assign credit      = r_credit;
   assign coin_reject = r_coin_reject;
   assign sel_reject  = r_sel_reject;
   assign soda_empty  = (r_soda_stock == '0);
   assign diet_empty  = (r_diet_stock == '0);
   assign busy        = (r_state == ST_DISPENSE) || (r_state == ST_CHANGE);

endmodule

`default_nettype wire

// File: tb/tb_vend_session_ctrl.sv
// ============================================================================
// Module   : tb_vend_session_ctrl
// Purpose  : Directed self-checking bench for vend_session_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vend_session_ctrl;

   logic       clk;
   logic       reset;
   logic       coin_n, coin_d, coin_q;
   logic       sel_valid, sel_diet, cancel, restock;
   logic       disp_ack, chg_ack;
   logic       disp_soda, disp_diet, chg_req;
   logic [3:0] credit;
   logic       coin_reject, sel_reject, soda_empty, diet_empty, busy;

   int n_cmp  = 0;
   int n_fail = 0;

   vend_session_ctrl #(
      .PRICE       (9),
      .STOCK_INIT  (8),
      .STOCK_W     (4),
      .TIMEOUT_CYC (16),
      .TMR_W       (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .coin_n      (coin_n),
      .coin_d      (coin_d),
      .coin_q      (coin_q),
      .sel_valid   (sel_valid),
      .sel_diet    (sel_diet),
      .cancel      (cancel),
      .restock     (restock),
      .disp_ack    (disp_ack),
      .chg_ack     (chg_ack),
      .disp_soda   (disp_soda),
      .disp_diet   (disp_diet),
      .chg_req     (chg_req),
      .credit      (credit),
      .coin_reject (coin_reject),
      .sel_reject  (sel_reject),
      .soda_empty  (soda_empty),
      .diet_empty  (diet_empty),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int v);
      coin_n = (v == 1);
      coin_d = (v == 2);
      coin_q = (v == 5);
      tick();
      coin_n = 1'b0;
      coin_d = 1'b0;
      coin_q = 1'b0;
   endtask

   task automatic select(input logic diet);
      sel_valid = 1'b1;
      sel_diet  = diet;
      tick();
      sel_valid = 1'b0;
      sel_diet  = 1'b0;
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   task automatic ack_disp();
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
   endtask

   task automatic drain(input int n);
      chg_ack = 1'b1;
      repeat (n) tick();
      chg_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      coin_n = 1'b0; coin_d = 1'b0; coin_q = 1'b0;
      sel_valid = 1'b0; sel_diet = 1'b0; cancel = 1'b0; restock = 1'b0;
      disp_ack = 1'b0; chg_ack = 1'b0;

      // Reset state
      tick();
      chk("rst_credit", 32'(credit), 32'd0);
      chk("rst_disp", 32'({disp_soda, disp_diet, chg_req}), 32'd0);
      chk("rst_pulses", 32'({coin_reject, sel_reject}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_empty", 32'({soda_empty, diet_empty}), 32'd0);
      reset = 1'b1;

      // Selection in IDLE is refused
      select(1'b0);
      chk("idle_sel_reject", 32'(sel_reject), 32'd1);
      chk("idle_sel_busy", 32'(busy), 32'd0);

      // Test 1: exact credit soda vend
      coin(5); chk("t1_credit5", 32'(credit), 32'd5);
      coin(2); chk("t1_credit7", 32'(credit), 32'd7);
      coin(2); chk("t1_credit9", 32'(credit), 32'd9);
      select(1'b0);
      chk("t1_disp_soda", 32'(disp_soda), 32'd1);
      chk("t1_disp_diet", 32'(disp_diet), 32'd0);
      chk("t1_credit0", 32'(credit), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      coin(1);
      chk("t1_disp_coin_rej", 32'(coin_reject), 32'd1);
      chk("t1_disp_credit", 32'(credit), 32'd0);
      chk("t1_disp_hold", 32'(disp_soda), 32'd1);
      ack_disp();
      chk("t1_ack_disp", 32'(disp_soda), 32'd0);
      chk("t1_ack_busy", 32'(busy), 32'd0);
      chk("t1_ack_chg", 32'(chg_req), 32'd0);

      // Test 2: diet vend with one nickel change
      coin(5); coin(5);
      chk("t2_credit10", 32'(credit), 32'd10);
      select(1'b1);
      chk("t2_disp_diet", 32'(disp_diet), 32'd1);
      chk("t2_credit1", 32'(credit), 32'd1);
      ack_disp();
      chk("t2_disp_drop", 32'(disp_diet), 32'd0);
      chk("t2_chg_req", 32'(chg_req), 32'd1);
      chk("t2_busy", 32'(busy), 32'd1);
      tick();
      chk("t2_chg_hold", 32'(chg_req), 32'd1);
      drain(1);
      chk("t2_credit0", 32'(credit), 32'd0);
      chk("t2_chg_drop", 32'(chg_req), 32'd0);
      chk("t2_idle", 32'(busy), 32'd0);

      // Test 3: coin rejected at full credit, then simultaneous coins
      coin(5); coin(2); coin(2);
      chk("t3_credit9", 32'(credit), 32'd9);
      coin(5);
      chk("t3_full_rej", 32'(coin_reject), 32'd1);
      chk("t3_full_credit", 32'(credit), 32'd9);
      tick();
      chk("t3_rej_pulse", 32'(coin_reject), 32'd0);
      pulse_cancel();
      chk("t3_cancel_chg", 32'(chg_req), 32'd1);
      drain(9);
      chk("t3_refund_credit", 32'(credit), 32'd0);
      chk("t3_refund_idle", 32'(busy), 32'd0);
      coin_n = 1'b1; coin_q = 1'b1;
      tick();
      coin_n = 1'b0; coin_q = 1'b0;
      chk("t3_multi_credit", 32'(credit), 32'd1);
      chk("t3_multi_rej", 32'(coin_reject), 32'd1);

      // Test 4: short selection, cancel refund of three nickels
      coin(2);
      chk("t4_credit3", 32'(credit), 32'd3);
      select(1'b0);
      chk("t4_sel_reject", 32'(sel_reject), 32'd1);
      chk("t4_sel_credit", 32'(credit), 32'd3);
      pulse_cancel();
      chk("t4_chg_req", 32'(chg_req), 32'd1);
      chk("t4_chg_credit", 32'(credit), 32'd3);
      drain(1); chk("t4_credit2", 32'(credit), 32'd2);
      drain(1); chk("t4_credit1", 32'(credit), 32'd1);
      drain(1); chk("t4_credit0", 32'(credit), 32'd0);
      chk("t4_idle", 32'({busy, chg_req}), 32'd0);

      // Test 4b: inactivity timeout after 16 idle cycles in CREDIT
      coin(1); coin(2);
      chk("t4b_credit3", 32'(credit), 32'd3);
      repeat (15) tick();
      chk("t4b_not_yet", 32'(busy), 32'd0);
      tick();
      chk("t4b_timeout_busy", 32'(busy), 32'd1);
      chk("t4b_timeout_chg", 32'(chg_req), 32'd1);
      drain(3);
      chk("t4b_refunded", 32'({busy, credit}), 32'd0);

      // Maximum credit boundary: 8 + quarter = 13
      coin(5); coin(2); coin(1); coin(5);
      chk("max_credit13", 32'(credit), 32'd13);
      chk("max_no_rej", 32'(coin_reject), 32'd0);
      pulse_cancel();
      drain(13);
      chk("max_refunded", 32'({busy, credit}), 32'd0);

      // Test 5: deplete soda stock from a fresh reset
      reset = 1'b0; tick(); reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         coin(5); coin(2); coin(2);
         select(1'b0);
         chk("t5_vend_disp", 32'(disp_soda), 32'd1);
         chk("t5_vend_empty", 32'(soda_empty), (i == 7) ? 32'd1 : 32'd0);
         ack_disp();
      end
      coin(5); coin(2); coin(2);
      select(1'b0);
      chk("t5_empty_sel_rej", 32'(sel_reject), 32'd1);
      chk("t5_empty_credit", 32'(credit), 32'd9);
      chk("t5_empty_nodisp", 32'({busy, disp_soda}), 32'd0);
      restock = 1'b1; tick(); restock = 1'b0;
      chk("t5_restock_ignored", 32'(soda_empty), 32'd1);
      pulse_cancel();
      drain(9);
      chk("t5_refunded", 32'({busy, credit}), 32'd0);
      restock = 1'b1; tick(); restock = 1'b0;
      chk("t5_restocked", 32'({soda_empty, diet_empty}), 32'd0);

      // Test 6: reset while dispensing diet
      coin(5); coin(5);
      select(1'b1);
      chk("t6_disp_diet", 32'(disp_diet), 32'd1);
      chk("t6_credit1", 32'(credit), 32'd1);
      reset = 1'b0; tick(); reset = 1'b1;
      chk("t6_rst_disp", 32'(disp_diet), 32'd0);
      chk("t6_rst_credit", 32'(credit), 32'd0);
      chk("t6_rst_busy", 32'({busy, chg_req}), 32'd0);
      chk("t6_rst_stock", 32'({soda_empty, diet_empty}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
